// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display bus: segment bit positions,
// digit patterns, strobe select codes and the reader FSM states.
package seven_seg_pkg;

  localparam int SEG_T  = 6;
  localparam int SEG_TR = 5;
  localparam int SEG_BR = 4;
  localparam int SEG_B  = 3;
  localparam int SEG_BL = 2;
  localparam int SEG_TL = 1;
  localparam int SEG_M  = 0;

  localparam logic [6:0] B_T  = 7'(1) << SEG_T;
  localparam logic [6:0] B_TR = 7'(1) << SEG_TR;
  localparam logic [6:0] B_BR = 7'(1) << SEG_BR;
  localparam logic [6:0] B_B  = 7'(1) << SEG_B;
  localparam logic [6:0] B_BL = 7'(1) << SEG_BL;
  localparam logic [6:0] B_TL = 7'(1) << SEG_TL;
  localparam logic [6:0] B_M  = 7'(1) << SEG_M;

  // Patterns are assembled from segment positions so they track the bus bit order.
  localparam logic [6:0] PAT_0 = B_T | B_TR | B_BR | B_B | B_BL | B_TL;
  localparam logic [6:0] PAT_1 = B_TR | B_BR;
  localparam logic [6:0] PAT_2 = B_T | B_TR | B_B | B_BL | B_M;
  localparam logic [6:0] PAT_3 = B_T | B_TR | B_BR | B_B | B_M;
  localparam logic [6:0] PAT_4 = B_TR | B_BR | B_TL | B_M;
  localparam logic [6:0] PAT_5 = B_T | B_BR | B_B | B_TL | B_M;
  localparam logic [6:0] PAT_6 = B_T | B_BR | B_B | B_BL | B_TL | B_M;
  localparam logic [6:0] PAT_7 = B_T | B_TR | B_BR;
  localparam logic [6:0] PAT_8 = B_T | B_TR | B_BR | B_B | B_BL | B_TL | B_M;
  localparam logic [6:0] PAT_9 = B_T | B_TR | B_BR | B_B | B_TL | B_M;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ONES = 2'b01;
  localparam logic [1:0] SEL_TENS = 2'b10;
  localparam logic [1:0] SEL_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment pattern to BCD decoder; anything outside the
// ten digit shapes (including blank) is flagged as not legal.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] digit
);

  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (seg)
      PAT_0:   digit = 4'd0;
      PAT_1:   digit = 4'd1;
      PAT_2:   digit = 4'd2;
      PAT_3:   digit = 4'd3;
      PAT_4:   digit = 4'd4;
      PAT_5:   digit = 4'd5;
      PAT_6:   digit = 4'd6;
      PAT_7:   digit = 4'd7;
      PAT_8:   digit = 4'd8;
      PAT_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Receiver for the two-digit multiplexed display bus: synchronizes, waits for
// each strobe to settle, decodes both digits and publishes the pair.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic       d1,
  input  logic       d2,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] value,
  output logic       value_valid,
  output logic       changed,
  output logic       seg_err,
  output logic       sel_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [6:0]       seg_m, seg_s;
  logic [1:0]       sel_m, sel;
  state_t           state;
  logic [1:0]       cur_sel;
  logic [CNT_W-1:0] cnt;
  logic             got_ones, got_tens;
  logic [3:0]       pend_ones, pend_tens;
  logic             sel_bad_d;

  logic       legal;
  logic [3:0] digit;
  logic       sel_legal;
  logic       pair_done;
  logic [3:0] nxt_ones, nxt_tens;
  logic [6:0] new_value;

  seven_seg_decode u_decode (
    .seg   (seg_s),
    .legal (legal),
    .digit (digit)
  );

  // The freshly sampled digit replaces its pending slot; the partner comes from the other slot.
  always_comb begin
    sel_legal = (sel == SEL_ONES) || (sel == SEL_TENS);
    nxt_ones  = (cur_sel == SEL_ONES) ? digit : pend_ones;
    nxt_tens  = (cur_sel == SEL_TENS) ? digit : pend_tens;
    pair_done = (cur_sel == SEL_ONES) ? got_tens : got_ones;
    new_value = ({3'b000, nxt_tens} << 3) + ({3'b000, nxt_tens} << 1) + {3'b000, nxt_ones};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_m       <= '0;
      seg_s       <= '0;
      sel_m       <= SEL_NONE;
      sel         <= SEL_NONE;
      state       <= ST_IDLE;
      cur_sel     <= SEL_NONE;
      cnt         <= '0;
      got_ones    <= 1'b0;
      got_tens    <= 1'b0;
      pend_ones   <= 4'd0;
      pend_tens   <= 4'd0;
      sel_bad_d   <= 1'b0;
      ones        <= 4'd0;
      tens        <= 4'd0;
      value       <= 7'd0;
      value_valid <= 1'b0;
      changed     <= 1'b0;
      seg_err     <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      seg_m       <= seg;
      seg_s       <= seg_m;
      sel_m       <= {d2, d1};
      sel         <= sel_m;
      sel_bad_d   <= (sel == SEL_BAD);
      value_valid <= 1'b0;
      changed     <= 1'b0;
      seg_err     <= 1'b0;
      sel_err     <= 1'b0;

      // Both strobes high overrides everything: abort any capture in progress.
      if (sel == SEL_BAD) begin
        sel_err  <= !sel_bad_d;
        state    <= ST_IDLE;
        got_ones <= 1'b0;
        got_tens <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sel_legal) begin
              cur_sel <= sel;
              cnt     <= '0;
              state   <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (sel == SEL_NONE) begin
              state <= ST_IDLE;
            end else if (sel != cur_sel) begin
              cur_sel <= sel;
              cnt     <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= ST_HOLD;
              if (!legal) begin
                seg_err  <= 1'b1;
                got_ones <= 1'b0;
                got_tens <= 1'b0;
              end else begin
                pend_ones <= nxt_ones;
                pend_tens <= nxt_tens;
                if (pair_done) begin
                  ones        <= nxt_ones;
                  tens        <= nxt_tens;
                  value       <= new_value;
                  value_valid <= 1'b1;
                  changed     <= (new_value != value);
                  got_ones    <= 1'b0;
                  got_tens    <= 1'b0;
                end else if (cur_sel == SEL_ONES) begin
                  got_ones <= 1'b1;
                end else begin
                  got_tens <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_HOLD: begin
            if (sel != cur_sel) begin
              if (sel_legal) begin
                cur_sel <= sel;
                cnt     <= '0;
                state   <= ST_SETTLE;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
